countdown_mmss: RTL

COUNTDOWN_MMSS -- requirements
Module: countdown_mmss

---
 rtl/countdown_pkg.sv | 23 ++
 rtl/bcd_down_digit.sv | 32 +++
 rtl/countdown_mmss.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/countdown_pkg.sv
// Shared types and constants for the MM:SS countdown timer.
// Imported by countdown_mmss and bcd_down_digit.
package countdown_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    ALARM  = 2'd3
  } state_t;

  localparam logic [3:0]  DIGIT_MAX9 = 4'd9;
  localparam logic [3:0]  DIGIT_MAX5 = 4'd5;
  localparam logic [15:0] ZERO_MMSS  = 16'h0000;

  function automatic logic mmss_valid(input logic [15:0] v);
    return (v[15:12] <= DIGIT_MAX5) &&
           (v[11:8]  <= DIGIT_MAX9) &&
           (v[7:4]   <= DIGIT_MAX5) &&
           (v[3:0]   <= DIGIT_MAX9);
  endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the countdown borrow chain.
// Wraps 0 -> MAX on borrow; borrow_out is combinational.
module bcd_down_digit
  import countdown_pkg::*;
#(
  parameter logic [3:0] MAX = DIGIT_MAX9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld,
  input  logic [3:0] ld_digit,
  input  logic       en,
  input  logic       borrow_in,
  output logic [3:0] digit,
  output logic       borrow_out
);

  // a digit steps only when the chain below it borrows
  assign borrow_out = borrow_in && (digit == 4'd0);

  // digit register: reset/clear, load, or decrement with wrap
  always_ff @(posedge clk) begin
    if (reset) begin
      digit <= 4'd0;
    end else if (ld) begin
      digit <= ld_digit;
    end else if (en && borrow_in) begin
      digit <= (digit == 4'd0) ? MAX : digit - 4'd1;
    end
  end

endmodule

// File: rtl/countdown_mmss.sv
// MM:SS BCD countdown timer with alarm hold-off.
// Optional door interlock: define DOOR_INTERLOCK_EN.
module countdown_mmss
  import countdown_pkg::*;
#(
  parameter int ALARM_TICKS = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        load,
  input  logic [15:0] load_value,
  input  logic        start,
  input  logic        pause,
  input  logic        clear,
`ifdef DOOR_INTERLOCK_EN
  input  logic        door_open,
`endif
  output logic [15:0] count,
  output logic        running,
  output logic        done,
  output logic        alarm
);

  localparam int AW =
    (ALARM_TICKS > 1) ? $clog2(ALARM_TICKS + 1) : 1;
  localparam logic [AW-1:0] ALARM_LAST = AW'(ALARM_TICKS);

  state_t        state;
  logic [AW-1:0] acnt;
  logic [AW-1:0] acnt_nxt;

  logic idle_or_paused;
  logic is_zero;
  logic is_one;
  logic door_hold;
  logic act_clear;
  logic act_load;
  logic act_start;
  logic act_pause;
  logic step;
  logic last_step;
  logic alarm_step;
  logic b_su;
  logic b_st;
  logic b_mu;
  logic b_mt;
  logic digit_rst;

`ifdef DOOR_INTERLOCK_EN
  assign door_hold = door_open;
`else
  assign door_hold = 1'b0;
`endif

  // control arbitration: clear > load > start > pause
  always_comb begin
    idle_or_paused = (state == IDLE) || (state == PAUSED);
    is_zero   = (count == ZERO_MMSS);
    is_one    = (count == 16'h0001);
    act_clear = clear;
    act_load  = !clear && load && idle_or_paused &&
                mmss_valid(load_value);
    act_start = !clear && !act_load && start &&
                idle_or_paused && !is_zero && !door_hold;
    act_pause = !clear && (state == RUN) &&
                (pause || door_hold);
    step      = tick && (state == RUN) && !act_clear &&
                !act_pause;
    last_step = step && is_one;
    alarm_step = tick && (state == ALARM) && !clear;
    acnt_nxt  = acnt + AW'(1);
    digit_rst = reset || act_clear;
  end

  // state, alarm counter and done pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      acnt  <= '0;
      done  <= 1'b0;
    end else begin
      done <= last_step;
      unique case (1'b1)
        act_clear: begin
          state <= IDLE;
          acnt  <= '0;
        end
        act_start: state <= RUN;
        act_pause: state <= PAUSED;
        last_step: begin
          state <= ALARM;
          acnt  <= '0;
        end
        alarm_step: begin
          acnt <= acnt_nxt;
          if (acnt_nxt >= ALARM_LAST) begin
            state <= IDLE;
          end
        end
        default: ;
      endcase
    end
  end

  assign running = (state == RUN);
  assign alarm   = (state == ALARM);

  assign b_su = 1'b1;

  bcd_down_digit #(.MAX(DIGIT_MAX9)) u_su (
    .clk        (clk),
    .reset      (digit_rst),
    .ld         (act_load),
    .ld_digit   (load_value[3:0]),
    .en         (step),
    .borrow_in  (b_su),
    .digit      (count[3:0]),
    .borrow_out (b_st)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX5)) u_st (
    .clk        (clk),
    .reset      (digit_rst),
    .ld         (act_load),
    .ld_digit   (load_value[7:4]),
    .en         (step),
    .borrow_in  (b_st),
    .digit      (count[7:4]),
    .borrow_out (b_mu)
  );

  bcd_down_digit #(.MAX(DIGIT_MAX9)) u_mu (
    .clk        (clk),
    .reset      (digit_rst),
    .ld         (act_load),
    .ld_digit   (load_value[11:8]),
    .en         (step),
    .borrow_in  (b_mu),
    .digit      (count[11:8]),
    .borrow_out (b_mt)
  );

  // minute tens never borrows further: count is nonzero in RUN
  bcd_down_digit #(.MAX(DIGIT_MAX5)) u_mt (
    .clk        (clk),
    .reset      (digit_rst),
    .ld         (act_load),
    .ld_digit   (load_value[15:12]),
    .en         (step),
    .borrow_in  (b_mt),
    .digit      (count[15:12]),
    .borrow_out ()
  );

endmodule
